// File: rtl/booth_mult_seq.sv
// -----------------------------------------------------------------------------
// booth_mult_seq
// Sequential control and accumulation stage of the iterative MIPS multiplier.
// Recodes the 32-bit multiplier into radix-16 Booth digits (one per cycle),
// drives the external partial-product stage with the digit's multiple
// selects and sign, and sums the three returned partial products into a
// 64-bit accumulator.
//
// Ports:
//   Clk, nReset        clock, asynchronous active-low reset
//   Start, Signed      request and operand signedness (sampled in IDLE only)
//   MultA, MultB       multiplicand / multiplier (sampled with Start)
//   Busy, Done         high in RUN/DONE; one-cycle result-valid pulse
//   Product            64-bit result, held until the next accepted Start
//   SelBoothA/B/C,Sign multiple selects and digit sign to partial-product stage
//   A                  current shifted multiplicand to partial-product stage
//   AfterA             A<<4 returned from partial-product stage
//   BoothA/B/C         partial products returned from partial-product stage
// -----------------------------------------------------------------------------
module booth_mult_seq (
   input  logic        Clk,
   input  logic        nReset,
   input  logic        Start,
   input  logic        Signed,
   input  logic [31:0] MultA,
   input  logic [31:0] MultB,
   output logic        Busy,
   output logic        Done,
   output logic [63:0] Product,
   output logic [2:0]  SelBoothA,
   output logic [1:0]  SelBoothB,
   output logic        SelBoothC,
   output logic        Sign,
   output logic [63:0] A,
   input  logic [63:0] AfterA,
   input  logic [63:0] BoothA,
   input  logic [63:0] BoothB,
   input  logic [63:0] BoothC
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q;
   logic [63:0] a_q;
   logic [63:0] acc_q;
   logic [63:0] acc_d;
   logic [63:0] prod_q;
   logic [35:0] mplr_q;
   logic        bm1_q;      // b[-1]: bit shifted out of the previous digit
   logic [3:0]  cnt_q;
   logic [3:0]  last_q;     // N-1: 7 signed, 8 unsigned
   logic        busy_q;
   logic        done_q;

   // Digit value: low nibble as a signed 4-bit number plus b[-1], -8..+8.
   logic signed [4:0] dig;
   logic        [4:0] dig_neg;
   logic        [3:0] mag;
   logic              run;

   assign run     = (state_q == S_RUN);
   assign dig     = $signed({mplr_q[3], mplr_q[3:0]}) + $signed({4'b0000, bm1_q});
   assign dig_neg = -dig;
   assign mag     = dig[4] ? dig_neg[3:0] : dig[3:0];

   // Magnitude split over three muxes: A picks 0/1/2/4/8, B 0/1/2, C 0/1.
   always_comb begin
      SelBoothA = 3'd0;
      SelBoothB = 2'd0;
      SelBoothC = 1'b0;
      Sign      = 1'b0;
      if (run) begin
         Sign = dig[4];
         unique case (mag)
            4'd1:    SelBoothA = 3'd1;
            4'd2:    SelBoothA = 3'd2;
            4'd3:    begin SelBoothA = 3'd2; SelBoothB = 2'd1; end
            4'd4:    SelBoothA = 3'd3;
            4'd5:    begin SelBoothA = 3'd3; SelBoothB = 2'd1; end
            4'd6:    begin SelBoothA = 3'd3; SelBoothB = 2'd2; end
            4'd7:    begin SelBoothA = 3'd3; SelBoothB = 2'd2; SelBoothC = 1'b1; end
            4'd8:    SelBoothA = 3'd4;
            default: ;
         endcase
      end
   end

   assign acc_d = acc_q + BoothA + BoothB + BoothC;

   always_ff @(posedge Clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
         mplr_q  <= '0;
         bm1_q   <= 1'b0;
         cnt_q   <= '0;
         last_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (Start) begin
                  state_q <= S_RUN;
                  a_q     <= {{32{Signed & MultA[31]}}, MultA};
                  mplr_q  <= {{4{Signed & MultB[31]}}, MultB};
                  bm1_q   <= 1'b0;
                  acc_q   <= '0;
                  cnt_q   <= '0;
                  last_q  <= Signed ? 4'd7 : 4'd8;
                  busy_q  <= 1'b1;
               end
            end
            S_RUN: begin
               acc_q  <= acc_d;
               a_q    <= AfterA;
               mplr_q <= {4'b0000, mplr_q[35:4]};
               bm1_q  <= mplr_q[3];
               cnt_q  <= cnt_q + 4'd1;
               if (cnt_q == last_q) begin
                  // Capture on the last digit so Product is valid alongside Done.
                  state_q <= S_DONE;
                  prod_q  <= acc_d;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign Product = prod_q;
   assign A       = a_q;

endmodule

// File: tb/tb_booth_mult_seq.sv
// -----------------------------------------------------------------------------
// tb_booth_mult_seq
// Directed bench for booth_mult_seq. A behavioural partial-product stage
// (multiple select, negate, shift) closes the loop around the DUT.
// -----------------------------------------------------------------------------
module tb_booth_mult_seq;

   logic        Clk = 1'b0;
   logic        nReset;
   logic        Start;
   logic        Signed;
   logic [31:0] MultA;
   logic [31:0] MultB;
   logic        Busy;
   logic        Done;
   logic [63:0] Product;
   logic [2:0]  SelBoothA;
   logic [1:0]  SelBoothB;
   logic        SelBoothC;
   logic        Sign;
   logic [63:0] A;
   logic [63:0] AfterA;
   logic [63:0] BoothA;
   logic [63:0] BoothB;
   logic [63:0] BoothC;

   int passed = 0;
   int total  = 0;

   booth_mult_seq dut (
      .Clk(Clk), .nReset(nReset), .Start(Start), .Signed(Signed),
      .MultA(MultA), .MultB(MultB), .Busy(Busy), .Done(Done),
      .Product(Product), .SelBoothA(SelBoothA), .SelBoothB(SelBoothB),
      .SelBoothC(SelBoothC), .Sign(Sign), .A(A), .AfterA(AfterA),
      .BoothA(BoothA), .BoothB(BoothB), .BoothC(BoothC)
   );

   always #5 Clk = ~Clk;

   // Partial-product stage model
   logic [63:0] ppa, ppb, ppc;
   always_comb begin
      ppa = 64'd0;
      ppb = 64'd0;
      ppc = 64'd0;
      case (SelBoothA)
         3'd1: ppa = A;
         3'd2: ppa = A << 1;
         3'd3: ppa = A << 2;
         3'd4: ppa = A << 3;
         default: ppa = 64'd0;
      endcase
      case (SelBoothB)
         2'd1: ppb = A;
         2'd2: ppb = A << 1;
         default: ppb = 64'd0;
      endcase
      if (SelBoothC) ppc = A;
   end
   assign BoothA = Sign ? -ppa : ppa;
   assign BoothB = Sign ? -ppb : ppb;
   assign BoothC = Sign ? -ppc : ppc;
   assign AfterA = A << 4;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   // Present a request at a negedge; it is accepted at the following posedge.
   task automatic start_op(input logic s, input logic [31:0] a, input logic [31:0] b);
      @(negedge Clk);
      Signed = s; MultA = a; MultB = b; Start = 1'b1;
      @(posedge Clk);
      #1 Start = 1'b0;
   endtask

   // Count negedges after the accept edge until Done (bounded).
   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge Clk);
         cyc++;
         if (Done) return;
      end
      cyc = -1;
   endtask

   task automatic run_case(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
      int cyc;
      start_op(s, a, b);
      wait_done(cyc);
      chk({tag, "_lat"}, 64'(cyc), s ? 64'd9 : 64'd10);
      chk({tag, "_prod"}, Product, exp);
      @(negedge Clk);
      chk({tag, "_idle"}, {62'd0, Busy, Done}, 64'd0);
   endtask

   initial begin
      int cyc;
      int pulses;
      logic [63:0] got;
      nReset = 1'b0; Start = 1'b0; Signed = 1'b0; MultA = '0; MultB = '0;
      #12;
      chk("rst_prod", Product, 64'd0);
      chk("rst_a", A, 64'd0);
      chk("rst_ctl", {58'd0, Busy, Done, SelBoothA, SelBoothB, SelBoothC, Sign}, 64'd0);
      @(negedge Clk);
      nReset = 1'b1;
      repeat (2) @(negedge Clk);
      chk("idle_nostart", {62'd0, Busy, Done}, 64'd0);

      run_case("s3xm5", 1'b1, 32'd3, 32'hFFFFFFFB, 64'hFFFFFFFFFFFFFFF1);
      repeat (3) @(negedge Clk);
      chk("prod_hold", Product, 64'hFFFFFFFFFFFFFFF1);
      run_case("u_ff", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001);
      run_case("s_ff", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h0000000000000001);
      run_case("s_min", 1'b1, 32'h80000000, 32'h80000000, 64'h4000000000000000);
      run_case("s_max", 1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 64'h3FFFFFFF00000001);

      // Sign extension of the loaded multiplicand
      start_op(1'b1, 32'h80000000, 32'd1);
      @(negedge Clk);
      chk("load_sext", A, 64'hFFFFFFFF80000000);
      chk("busy_run", {63'd0, Busy}, 64'd1);
      wait_done(cyc);
      chk("sext_prod", Product, 64'hFFFFFFFF80000000);

      // Digit mapping: +7 -> (3,2,1,+)
      start_op(1'b1, 32'd5, 32'd7);
      @(negedge Clk);
      chk("dig7", {58'd0, SelBoothA, SelBoothB, SelBoothC, Sign}, {58'd0, 3'd3, 2'd2, 1'b1, 1'b0});
      wait_done(cyc);
      chk("dig7_prod", Product, 64'd35);

      // 8 recodes as -8 then +1
      start_op(1'b1, 32'd9, 32'd8);
      @(negedge Clk);
      chk("dig8_c0", {58'd0, SelBoothA, SelBoothB, SelBoothC, Sign}, {58'd0, 3'd4, 2'd0, 1'b0, 1'b1});
      @(negedge Clk);
      chk("dig8_c1", {58'd0, SelBoothA, SelBoothB, SelBoothC, Sign}, {58'd0, 3'd1, 2'd0, 1'b0, 1'b0});
      wait_done(cyc);
      chk("dig8_prod", Product, 64'd72);

      // Start re-pulsed during RUN must be ignored
      start_op(1'b1, 32'd1234, 32'd5678);
      repeat (2) @(negedge Clk);
      Signed = 1'b0; MultA = 32'd11; MultB = 32'd13; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      pulses = 0; got = '0;
      for (int i = 0; i < 15; i++) begin
         @(negedge Clk);
         if (Done) begin pulses++; got = Product; end
      end
      chk("repulse_cnt", 64'(pulses), 64'd1);
      chk("repulse_prod", got, 64'd7006652);

      // Reset mid-RUN aborts
      start_op(1'b1, 32'd100, 32'd100);
      repeat (3) @(negedge Clk);
      nReset = 1'b0;
      #1;
      chk("abort_ctl", {58'd0, Busy, Done, SelBoothA, SelBoothB, SelBoothC, Sign}, 64'd0);
      chk("abort_prod", Product, 64'd0);
      chk("abort_a", A, 64'd0);
      @(negedge Clk);
      nReset = 1'b1;
      run_case("post_rst", 1'b1, 32'd2, 32'd3, 64'd6);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Sequential control and accumulation stage for the MIPS iterative multiplier.
- Drives the Booth partial-product stage, which shifts the multiplicand and builds the 0/±1/±2/±4/±8 multiple select muxes.
- Recodes the 32-bit multiplier into radix-16 Booth digits, one digit per cycle, and sums the three returned partial products into a 64-bit accumulator.
- Provides a Start/Done handshake to the MIPS EX stage.

Parameters:
- None. Widths are fixed: 32-bit operands, 64-bit product.

Ports:
- Clk  input  1  rising-edge clock.
- nReset  input  1  asynchronous, active-low reset.
- Start  input  1  request. Sampled only in IDLE.
- Signed  input  1  1 = two's-complement operands, 0 = unsigned. Sampled with Start.
- MultA  input  32  multiplicand. Sampled with Start.
- MultB  input  32  multiplier. Sampled with Start.
- Busy  output  1  high in RUN and DONE.
- Done  output  1  one-cycle pulse; Product is valid when it is high.
- Product  output  64  result. Held until the next accepted Start.
- SelBoothA  output  3  to partial-product stage. Selects 0/1/2/4/8 for codes 0..4.
- SelBoothB  output  2  to partial-product stage. Selects 0/1/2 for codes 0..2.
- SelBoothC  output  1  to partial-product stage. Selects 0/1.
- Sign  output  1  to partial-product stage. 1 = current digit is negative.
- A  output  64  current shifted multiplicand register, to partial-product stage.
- AfterA  input  64  A<<4 returned from partial-product stage.
- BoothA, BoothB, BoothC  input  64 each  partial products returned from partial-product stage.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset state:
  - State=IDLE.
  - A, accumulator, multiplier shift register, counter, Product = 0.
  - Busy=0, Done=0.
  - Select outputs = 0, Sign=0.
- Reset asserted mid-operation aborts immediately to the reset state. No Done is produced.
- States and transitions:
  - IDLE: Start=1 at a clock edge performs the load and moves to RUN. Start=0 stays in IDLE.
  - RUN: one Booth digit per cycle. Exits to DONE after the last digit.
  - DONE: Done=1 and Product updated for exactly one cycle, then IDLE.
- Load (on the edge where Start is accepted):
  - A = MultA sign-extended (Signed=1) or zero-extended (Signed=0) to 64 bits.
  - Multiplier register (36 bits) = {4 copies of MultB[31] if Signed else 4'b0, MultB}. Previous bit b[-1] = 0.
  - Accumulator = 0. Counter = 0.
  - Digit count N = 8 when Signed=1, 9 when Signed=0.
- Digit i encoding:
  - d = -8·b[4i+3] + 4·b[4i+2] + 2·b[4i+1] + b[4i] + b[4i-1], range -8..+8.
  - Sign = (d<0). Magnitude m = |d|.
- Magnitude to (SelBoothA, SelBoothB, SelBoothC), fixed mapping:
  - 0→(0,0,0), 1→(1,0,0), 2→(2,0,0), 3→(2,1,0), 4→(3,0,0)
  - 5→(3,1,0), 6→(3,2,0), 7→(3,2,1), 8→(4,0,0)
- Selects and Sign are combinational from the multiplier register low 4 bits plus the saved b[-1], valid only in RUN. Outside RUN they are forced to 0.
- Each RUN edge:
  - Accumulator += BoothA + BoothB + BoothC, modulo 2^64. Overflow is discarded.
  - A ← AfterA.
  - Multiplier register shifts right by 4. b[-1] ← old bit 3.
  - Counter increments. When Counter reaches N-1, next state is DONE.
- DONE edge: Product ← accumulator. Done is asserted in that same DONE cycle, Product visible with it.
- Latency: Start sampled at edge k → Done high in the cycle after edge k+N, i.e. the product appears N+1 cycles after Start. That is 9 cycles signed, 10 cycles unsigned.
- Start while Busy=1 is ignored; inputs are not re-sampled. Start high in the DONE cycle is also ignored. Start is re-accepted only in IDLE.
- Done=0 whenever not in DONE. Product is unchanged except at the DONE edge.

Test Plan:
- Signed=1, MultA=3, MultB=0xFFFFFFFB (-5) → Done after 9 cycles, Product=0xFFFFFFFFFFFFFFF1.
- Signed=0, MultA=MultB=0xFFFFFFFF → Done after 10 cycles, Product=0xFFFFFFFE00000001. Same operands with Signed=1 → 0x0000000000000001.
- Signed=1, MultA=MultB=0x80000000 → 0x4000000000000000. MultA=MultB=0x7FFFFFFF → 0x3FFFFFFF00000001.
- Digit mapping check: MultB=0x00000007, Signed=1, first RUN cycle → (SelBoothA,SelBoothB,SelBoothC,Sign)=(3,2,1,0). MultB=0x00000008 → (4,0,0,1) in the first RUN cycle, +1 digit in the second RUN cycle; Product=8·MultA.
- Start pulsed again in RUN with different operands → ignored. Original Product is returned and exactly one Done pulse occurs.
- nReset low mid-RUN → all outputs 0 and state IDLE immediately. After release, a new Start with 2×3 → Product=6.
